// File: rtl/ace_aw_snoop_sequencer.sv
// ACE AW snoop sequencer: decodes an upstream AW, issues AC snoops to all snoopers,
// collects CRs, then forwards the AW. Optional snoop timeout via ACE_SNOOP_TIMEOUT_EN.

package ace_aw_snoop_sequencer_pkg;
    typedef struct packed {
        logic [2:0]  snoop;
        logic [1:0]  domain;
        logic [1:0]  bar;
        logic [5:0]  atop;
        logic [63:0] addr;
    } aw_chan_t;
endpackage

module ace_aw_snoop_sequencer #(
    parameter type         aw_chan_t     = ace_aw_snoop_sequencer_pkg::aw_chan_t,
    parameter int unsigned AddrWidth     = 64,
    parameter int unsigned NumSnoopers   = 2,
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  aw_chan_t                 slv_aw_i,
    input  logic                     slv_aw_valid_i,
    output logic                     slv_aw_ready_o,
    output aw_chan_t                 mst_aw_o,
    output logic                     mst_aw_valid_o,
    input  logic                     mst_aw_ready_i,
    output logic [NumSnoopers-1:0]   ac_valid_o,
    input  logic [NumSnoopers-1:0]   ac_ready_i,
    output logic [AddrWidth-1:0]     ac_addr_o,
    output logic [3:0]               ac_snoop_o,
    input  logic [NumSnoopers-1:0]   cr_valid_i,
    output logic [NumSnoopers-1:0]   cr_ready_o,
    input  logic [5*NumSnoopers-1:0] cr_resp_i,
    output logic                     pass_dirty_o,
    output logic                     error_o,
    output logic                     illegal_o,
    output logic                     timeout_o
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SNOOP = 2'd1;
    localparam logic [1:0] FWD   = 2'd2;

    localparam logic [3:0] AC_CLEAN_INVALID = 4'b1001;
    localparam logic [3:0] AC_MAKE_INVALID  = 4'b1101;

    logic [1:0]             state;
    aw_chan_t               aw_q;
    logic [3:0]             code_q;
    logic [NumSnoopers-1:0] ac_done, cr_done, ac_hs, cr_hs;
    logic [NumSnoopers-1:0] resp_pd, resp_err;
    logic                   pass_dirty_q, error_q, illegal_q;
    logic                   dec_snoop, dec_legal;
    logic [3:0]             dec_code;
    logic                   shareable, non_system;
    logic                   all_done_next;
    logic                   timeout_hit;
    logic                   timeout_q;
    logic                   unused_resp;

    always_comb begin
        dec_snoop  = 1'b0;
        dec_legal  = 1'b0;
        dec_code   = '0;
        shareable  = (slv_aw_i.domain == 2'b01) || (slv_aw_i.domain == 2'b10);
        non_system = (slv_aw_i.domain != 2'b11);
        if (slv_aw_i.atop != '0) begin
            dec_snoop = 1'b1;
            dec_code  = AC_CLEAN_INVALID;
        end else if (slv_aw_i.bar != '0) begin
            dec_legal = 1'b1;
        end else begin
            case (slv_aw_i.snoop)
                3'b000: begin
                    if (shareable) begin
                        dec_snoop = 1'b1;
                        dec_code  = AC_CLEAN_INVALID;
                    end else if (slv_aw_i.domain == 2'b00) begin
                        dec_legal = 1'b1;
                    end
                end
                3'b001: begin
                    if (shareable) begin
                        dec_snoop = 1'b1;
                        dec_code  = AC_MAKE_INVALID;
                    end
                end
                3'b010, 3'b011, 3'b101: dec_legal = non_system;
                3'b100:                 dec_legal = shareable;
                default:                dec_legal = 1'b0;
            endcase
        end
    end

    always_comb begin
        resp_pd  = '0;
        resp_err = '0;
        for (int unsigned i = 0; i < NumSnoopers; i++) begin
            resp_pd[i]  = cr_resp_i[5*i+2];
            resp_err[i] = cr_resp_i[5*i+1];
        end
    end

    assign unused_resp = ^cr_resp_i;

    assign ac_valid_o    = (!rst_i && state == SNOOP) ? ~ac_done : '0;
    assign cr_ready_o    = (!rst_i && state == SNOOP) ? (ac_done & ~cr_done) : '0;
    assign ac_hs         = ac_valid_o & ac_ready_i;
    assign cr_hs         = cr_ready_o & cr_valid_i;
    // Exit decision includes this cycle's handshakes so FWD follows the last CR directly.
    assign all_done_next = (&(ac_done | ac_hs)) && (&(cr_done | cr_hs));

    assign slv_aw_ready_o = !rst_i && (state == IDLE);
    assign mst_aw_valid_o = !rst_i && (state == FWD);
    assign ac_addr_o      = rst_i ? '0 : AddrWidth'(aw_q.addr);
    assign ac_snoop_o     = rst_i ? '0 : code_q;
    assign pass_dirty_o   = !rst_i && pass_dirty_q;
    assign error_o        = !rst_i && error_q;
    assign illegal_o      = !rst_i && illegal_q;
    assign timeout_o      = !rst_i && timeout_q;

    always_comb begin
        if (rst_i) mst_aw_o = '0;
        else       mst_aw_o = aw_q;
    end

`ifdef ACE_SNOOP_TIMEOUT_EN
    localparam int unsigned CntW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
    logic [CntW-1:0] cnt;

    assign timeout_hit = (state == SNOOP) && !all_done_next &&
                         (cnt == CntW'(TimeoutCycles - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt       <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt       <= (state == SNOOP) ? cnt + 1'b1 : '0;
            timeout_q <= timeout_hit;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign timeout_q   = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= IDLE;
            aw_q         <= '0;
            code_q       <= '0;
            ac_done      <= '0;
            cr_done      <= '0;
            pass_dirty_q <= 1'b0;
            error_q      <= 1'b0;
            illegal_q    <= 1'b0;
        end else begin
            illegal_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (slv_aw_valid_i) begin
                        pass_dirty_q <= 1'b0;
                        error_q      <= 1'b0;
                        ac_done      <= '0;
                        cr_done      <= '0;
                        if (dec_snoop) begin
                            aw_q   <= slv_aw_i;
                            code_q <= dec_code;
                            state  <= SNOOP;
                        end else if (dec_legal) begin
                            aw_q   <= slv_aw_i;
                            code_q <= '0;
                            state  <= FWD;
                        end else begin
                            illegal_q <= 1'b1;
                        end
                    end
                end
                SNOOP: begin
                    ac_done      <= ac_done | ac_hs;
                    cr_done      <= cr_done | cr_hs;
                    pass_dirty_q <= pass_dirty_q | (|(cr_hs & resp_pd));
                    if (all_done_next) begin
                        error_q <= error_q | (|(cr_hs & resp_err));
                        state   <= FWD;
                    end else if (timeout_hit) begin
                        error_q <= 1'b1;
                        state   <= FWD;
                    end else begin
                        error_q <= error_q | (|(cr_hs & resp_err));
                    end
                end
                FWD: begin
                    if (mst_aw_ready_i) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ace_aw_snoop_sequencer.sv
// Directed self-checking bench for ace_aw_snoop_sequencer (NumSnoopers=2, TimeoutCycles=16).

module tb_ace_aw_snoop_sequencer;

    typedef ace_aw_snoop_sequencer_pkg::aw_chan_t aw_t;

    logic        clk = 1'b0;
    logic        rst;
    aw_t         aw, mst_aw, exp_aw;
    logic        aw_valid, aw_ready, mst_valid, mst_ready;
    logic [1:0]  ac_valid, ac_ready, cr_valid, cr_ready;
    logic [63:0] ac_addr;
    logic [3:0]  ac_snoop;
    logic [9:0]  cr_resp;
    logic        pass_dirty, error, illegal, timeout;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    ace_aw_snoop_sequencer #(
        .aw_chan_t     (aw_t),
        .AddrWidth     (64),
        .NumSnoopers   (2),
        .TimeoutCycles (16)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .slv_aw_i       (aw),
        .slv_aw_valid_i (aw_valid),
        .slv_aw_ready_o (aw_ready),
        .mst_aw_o       (mst_aw),
        .mst_aw_valid_o (mst_valid),
        .mst_aw_ready_i (mst_ready),
        .ac_valid_o     (ac_valid),
        .ac_ready_i     (ac_ready),
        .ac_addr_o      (ac_addr),
        .ac_snoop_o     (ac_snoop),
        .cr_valid_i     (cr_valid),
        .cr_ready_o     (cr_ready),
        .cr_resp_i      (cr_resp),
        .pass_dirty_o   (pass_dirty),
        .error_o        (error),
        .illegal_o      (illegal),
        .timeout_o      (timeout)
    );

    // Presents one AW for a single cycle; returns at the negedge after acceptance.
    task automatic drive_aw(input logic [2:0] sn, input logic [1:0] dom, input logic [1:0] bar,
                            input logic [5:0] atop, input logic [63:0] addr);
        aw.snoop  = sn;
        aw.domain = dom;
        aw.bar    = bar;
        aw.atop   = atop;
        aw.addr   = addr;
        exp_aw    = aw;
        aw_valid  = 1'b1;
        @(negedge clk);
        aw_valid  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; aw = '0; aw_valid = 1'b0; mst_ready = 1'b0;
        ac_ready = 2'b00; cr_valid = 2'b00; cr_resp = '0;
        repeat (2) @(negedge clk);
        total++;
        if ({aw_ready, mst_valid} !== 2'b00) begin
            bad++; $display("FAIL reset_ready_valid: got %b want 00", {aw_ready, mst_valid});
        end
        total++;
        if ({ac_valid, cr_ready} !== 4'b0000) begin
            bad++; $display("FAIL reset_ac_cr: got %b want 0000", {ac_valid, cr_ready});
        end
        total++;
        if ({pass_dirty, error, illegal, timeout} !== 4'b0000) begin
            bad++; $display("FAIL reset_flags: got %b want 0000", {pass_dirty, error, illegal, timeout});
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (aw_ready !== 1'b1) begin
            bad++; $display("FAIL reset_release_ready: got %b want 1", aw_ready);
        end
    endtask

    task automatic test_no_snoop();
        mst_ready = 1'b1;
        drive_aw(3'b000, 2'b00, 2'b00, 6'd0, 64'h1000);
        total++;
        if ({mst_valid, ac_valid, aw_ready} !== 4'b1000) begin
            bad++; $display("FAIL nosnoop_latency: got %b want 1000", {mst_valid, ac_valid, aw_ready});
        end
        total++;
        if (mst_aw !== exp_aw) begin
            bad++; $display("FAIL nosnoop_aw: got %h want %h", mst_aw, exp_aw);
        end
        @(negedge clk);
        total++;
        if ({mst_valid, aw_ready} !== 2'b01) begin
            bad++; $display("FAIL nosnoop_done: got %b want 01", {mst_valid, aw_ready});
        end
    endtask

    task automatic test_line_unique();
        mst_ready = 1'b0; ac_ready = 2'b01; cr_valid = 2'b00; cr_resp = '0;
        drive_aw(3'b001, 2'b01, 2'b00, 6'd0, 64'h2040);
        total++;
        if ({ac_valid, cr_ready} !== 4'b1100) begin
            bad++; $display("FAIL lu_s0_ac_cr: got %b want 1100", {ac_valid, cr_ready});
        end
        total++;
        if ({ac_snoop, ac_addr} !== {4'b1101, 64'h2040}) begin
            bad++; $display("FAIL lu_snoop_addr: got %h/%h want d/2040", ac_snoop, ac_addr);
        end
        @(negedge clk);
        total++;
        if ({ac_valid, cr_ready} !== 4'b1001) begin
            bad++; $display("FAIL lu_s1_ac_cr: got %b want 1001", {ac_valid, cr_ready});
        end
        cr_valid = 2'b01;
        @(negedge clk);
        total++;
        if ({ac_valid, cr_ready, mst_valid} !== 5'b10000) begin
            bad++; $display("FAIL lu_s2_hold: got %b want 10000", {ac_valid, cr_ready, mst_valid});
        end
        cr_valid = 2'b00; ac_ready = 2'b10;
        @(negedge clk);
        total++;
        if ({ac_valid, cr_ready, mst_valid} !== 5'b00100) begin
            bad++; $display("FAIL lu_s3_cr1: got %b want 00100", {ac_valid, cr_ready, mst_valid});
        end
        total++;
        if ({ac_snoop, ac_addr} !== {4'b1101, 64'h2040}) begin
            bad++; $display("FAIL lu_stable: got %h/%h want d/2040", ac_snoop, ac_addr);
        end
        cr_valid = 2'b10;
        @(negedge clk);
        total++;
        if ({mst_valid, ac_valid, cr_ready, pass_dirty, error} !== 7'b1000000) begin
            bad++; $display("FAIL lu_fwd: got %b want 1000000", {mst_valid, ac_valid, cr_ready, pass_dirty, error});
        end
        total++;
        if (mst_aw !== exp_aw) begin
            bad++; $display("FAIL lu_fwd_aw: got %h want %h", mst_aw, exp_aw);
        end
        cr_valid = 2'b00; ac_ready = 2'b00; mst_ready = 1'b1;
        @(negedge clk);
        total++;
        if ({mst_valid, aw_ready} !== 2'b01) begin
            bad++; $display("FAIL lu_done: got %b want 01", {mst_valid, aw_ready});
        end
    endtask

    task automatic test_pass_dirty();
        mst_ready = 1'b0; ac_ready = 2'b11; cr_valid = 2'b00; cr_resp = '0;
        drive_aw(3'b000, 2'b10, 2'b00, 6'd0, 64'h3000);
        total++;
        if ({ac_valid, ac_snoop} !== {2'b11, 4'b1001}) begin
            bad++; $display("FAIL wu_ac: got %b want 111001", {ac_valid, ac_snoop});
        end
        @(negedge clk);
        cr_valid = 2'b11; cr_resp = {5'b00000, 5'b00100};
        @(negedge clk);
        total++;
        if ({mst_valid, pass_dirty, error} !== 3'b110) begin
            bad++; $display("FAIL wu_pass_dirty: got %b want 110", {mst_valid, pass_dirty, error});
        end
        cr_valid = 2'b00; cr_resp = '0; ac_ready = 2'b00; mst_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_illegal();
        mst_ready = 1'b1;
        drive_aw(3'b011, 2'b11, 2'b00, 6'd0, 64'h4000);
        total++;
        if ({illegal, mst_valid, aw_ready} !== 3'b101) begin
            bad++; $display("FAIL illegal_pulse: got %b want 101", {illegal, mst_valid, aw_ready});
        end
        drive_aw(3'b010, 2'b00, 2'b00, 6'd0, 64'h5000);
        total++;
        if ({illegal, mst_valid, pass_dirty} !== 3'b010) begin
            bad++; $display("FAIL illegal_next_aw: got %b want 010", {illegal, mst_valid, pass_dirty});
        end
        total++;
        if (mst_aw.addr !== 64'h5000) begin
            bad++; $display("FAIL illegal_next_addr: got %h want 5000", mst_aw.addr);
        end
        @(negedge clk);
    endtask

    typedef struct {
        logic [2:0] sn;
        logic [1:0] dom;
        logic [1:0] bar;
        logic [5:0] atop;
        int         kind;   // 0 forward, 1 illegal, 2 CleanInvalid, 3 MakeInvalid
    } vec_t;

    task automatic test_decode();
        vec_t v[6];
        int   n;
        v[0] = '{3'b100, 2'b01, 2'b00, 6'd0,  0};
        v[1] = '{3'b100, 2'b00, 2'b00, 6'd0,  1};
        v[2] = '{3'b000, 2'b01, 2'b01, 6'd0,  0};
        v[3] = '{3'b101, 2'b11, 2'b00, 6'd0,  1};
        v[4] = '{3'b000, 2'b00, 2'b00, 6'h21, 2};
        v[5] = '{3'b001, 2'b10, 2'b00, 6'd0,  3};
        mst_ready = 1'b1; ac_ready = 2'b11; cr_valid = 2'b11; cr_resp = '0;
        for (int i = 0; i < 6; i++) begin
            drive_aw(v[i].sn, v[i].dom, v[i].bar, v[i].atop, 64'h100 * i);
            total++;
            case (v[i].kind)
                0: if ({mst_valid, ac_valid, illegal} !== 4'b1000) begin
                    bad++; $display("FAIL decode_fwd[%0d]: got %b want 1000", i, {mst_valid, ac_valid, illegal});
                end
                1: if ({mst_valid, ac_valid, illegal} !== 4'b0001) begin
                    bad++; $display("FAIL decode_illegal[%0d]: got %b want 0001", i, {mst_valid, ac_valid, illegal});
                end
                2: if ({ac_valid, ac_snoop} !== {2'b11, 4'b1001}) begin
                    bad++; $display("FAIL decode_ci[%0d]: got %b want 111001", i, {ac_valid, ac_snoop});
                end
                default: if ({ac_valid, ac_snoop} !== {2'b11, 4'b1101}) begin
                    bad++; $display("FAIL decode_mi[%0d]: got %b want 111101", i, {ac_valid, ac_snoop});
                end
            endcase
            n = 0;
            while (aw_ready !== 1'b1 && n < 8) begin
                @(negedge clk);
                n++;
            end
            total++;
            if (aw_ready !== 1'b1) begin
                bad++; $display("FAIL decode_return_idle[%0d]: got %b want 1", i, aw_ready);
            end
        end
        ac_ready = 2'b00; cr_valid = 2'b00;
    endtask

    task automatic test_timeout();
        mst_ready = 1'b0; ac_ready = 2'b11; cr_valid = 2'b01; cr_resp = '0;
        drive_aw(3'b000, 2'b00, 2'b00, 6'h20, 64'h6000);
        total++;
        if (ac_valid !== 2'b11) begin
            bad++; $display("FAIL to_s0_ac: got %b want 11", ac_valid);
        end
`ifdef ACE_SNOOP_TIMEOUT_EN
        for (int i = 1; i < 16; i++) begin
            @(negedge clk);
            total++;
            if ({mst_valid, timeout} !== 2'b00) begin
                bad++; $display("FAIL to_wait[%0d]: got %b want 00", i, {mst_valid, timeout});
            end
        end
        @(negedge clk);
        total++;
        if ({mst_valid, timeout, error, ac_valid, cr_ready} !== 7'b1110000) begin
            bad++; $display("FAIL to_fire: got %b want 1110000", {mst_valid, timeout, error, ac_valid, cr_ready});
        end
        @(negedge clk);
        total++;
        if ({mst_valid, timeout, error} !== 3'b101) begin
            bad++; $display("FAIL to_pulse_end: got %b want 101", {mst_valid, timeout, error});
        end
        mst_ready = 1'b1;
        @(negedge clk);
        mst_ready = 1'b0;
        total++;
        if (aw_ready !== 1'b1) begin
            bad++; $display("FAIL to_idle: got %b want 1", aw_ready);
        end
        drive_aw(3'b000, 2'b00, 2'b00, 6'h20, 64'h7000);
        repeat (2) @(negedge clk);
`else
        repeat (40) @(negedge clk);
        total++;
        if ({mst_valid, timeout, ac_valid, cr_ready} !== 6'b000010) begin
            bad++; $display("FAIL no_to_wait: got %b want 000010", {mst_valid, timeout, ac_valid, cr_ready});
        end
`endif
    endtask

    task automatic test_reset_mid();
        mst_ready = 1'b1;
        rst = 1'b1;
        #1;
        total++;
        if ({aw_ready, mst_valid, ac_valid, cr_ready, pass_dirty, error, illegal, timeout} !== 10'b0) begin
            bad++; $display("FAIL rst_mid_outputs: got %b want 0", {aw_ready, mst_valid, ac_valid, cr_ready, pass_dirty, error, illegal, timeout});
        end
        @(negedge clk);
        total++;
        if ({aw_ready, mst_valid, ac_valid, cr_ready, error, timeout} !== 8'b0) begin
            bad++; $display("FAIL rst_mid_held: got %b want 0", {aw_ready, mst_valid, ac_valid, cr_ready, error, timeout});
        end
        rst = 1'b0; cr_valid = 2'b00; ac_ready = 2'b00;
        @(negedge clk);
        total++;
        if ({aw_ready, mst_valid} !== 2'b10) begin
            bad++; $display("FAIL rst_mid_release: got %b want 10", {aw_ready, mst_valid});
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if (mst_valid !== 1'b0) begin
                bad++; $display("FAIL rst_mid_no_fwd[%0d]: got %b want 0", i, mst_valid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_no_snoop();
        test_line_unique();
        test_pass_dirty();
        test_illegal();
        test_decode();
        test_timeout();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
